// File: rtl/l2_port_arbiter.sv
// Arbiter for the single L2 request port shared by the I-cache miss path and
// the D-cache miss/write-back path, with a per-transaction watchdog and statistics.
module l2_port_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int AW      = 26
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ic_req,
    input  logic [AW-1:0] ic_addr,
    input  logic          dc_req,
    input  logic [AW-1:0] dc_addr,
    input  logic          dc_we,
    input  logic          stat_clr,
    output logic          ic_gnt,
    output logic          dc_gnt,
    output logic          ic_done,
    output logic          dc_done,
    output logic          err,
    output logic          l2_req,
    output logic [AW-1:0] l2_addr,
    output logic          l2_we,
    input  logic          l2_ack,
    output logic [31:0]   ic_cnt,
    output logic [31:0]   dc_cnt,
    output logic [31:0]   conflicts,
    output logic [31:0]   timeouts
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic        owner_dc;
    logic        last_dc;
    logic        timed_out;
    logic [15:0] wd;

    logic grant;
    logic grant_dc;
    logic conflict;
    logic expire;

    // Tie goes to whichever requester was not granted last.
    always_comb begin
        grant    = (state == S_IDLE) && (ic_req || dc_req);
        conflict = grant && ic_req && dc_req;
        grant_dc = dc_req && (!ic_req || !last_dc);
        expire   = (state == S_ISSUE) && !l2_ack && (wd == WD_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            owner_dc  <= 1'b0;
            last_dc   <= 1'b1;
            timed_out <= 1'b0;
            wd        <= '0;
            ic_gnt    <= 1'b0;
            dc_gnt    <= 1'b0;
            ic_done   <= 1'b0;
            dc_done   <= 1'b0;
            err       <= 1'b0;
            l2_req    <= 1'b0;
            l2_addr   <= '0;
            l2_we     <= 1'b0;
        end else begin
            ic_gnt  <= 1'b0;
            dc_gnt  <= 1'b0;
            ic_done <= 1'b0;
            dc_done <= 1'b0;
            err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        owner_dc  <= grant_dc;
                        last_dc   <= grant_dc;
                        l2_addr   <= grant_dc ? dc_addr : ic_addr;
                        l2_we     <= grant_dc ? dc_we : 1'b0;
                        ic_gnt    <= !grant_dc;
                        dc_gnt    <= grant_dc;
                        l2_req    <= 1'b1;
                        wd        <= '0;
                        timed_out <= 1'b0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd <= wd + 16'd1;
                    if (l2_ack || expire) begin
                        timed_out <= expire;
                        l2_req    <= 1'b0;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    ic_done <= !owner_dc;
                    dc_done <= owner_dc;
                    err     <= timed_out;
                    state   <= S_IDLE;
                end
                default: begin
                    l2_req <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Clear takes priority over any increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ic_cnt    <= '0;
            dc_cnt    <= '0;
            conflicts <= '0;
            timeouts  <= '0;
        end else if (stat_clr) begin
            ic_cnt    <= '0;
            dc_cnt    <= '0;
            conflicts <= '0;
            timeouts  <= '0;
        end else begin
            if (grant && !grant_dc) ic_cnt <= ic_cnt + 32'd1;
            if (grant && grant_dc)  dc_cnt <= dc_cnt + 32'd1;
            if (conflict)           conflicts <= conflicts + 32'd1;
            if (expire)             timeouts <= timeouts + 32'd1;
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of grants, latency and statistics.
module tb_l2_port_arbiter;

    localparam int TO = 8;
    localparam int AW = 26;

    logic          clk;
    logic          rst_n;
    logic          ic_req, dc_req, dc_we, stat_clr, l2_ack;
    logic [AW-1:0] ic_addr, dc_addr;
    logic          ic_gnt, dc_gnt, ic_done, dc_done, err, l2_req, l2_we;
    logic [AW-1:0] l2_addr;
    logic [31:0]   ic_cnt, dc_cnt, conflicts, timeouts;

    l2_port_arbiter #(.TIMEOUT(TO), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_we(dc_we),
        .stat_clr(stat_clr),
        .ic_gnt(ic_gnt), .dc_gnt(dc_gnt),
        .ic_done(ic_done), .dc_done(dc_done), .err(err),
        .l2_req(l2_req), .l2_addr(l2_addr), .l2_we(l2_we), .l2_ack(l2_ack),
        .ic_cnt(ic_cnt), .dc_cnt(dc_cnt), .conflicts(conflicts), .timeouts(timeouts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic        m_last_dc;
    logic [31:0] m_ic, m_dc, m_conf, m_to;
    logic        ic_pend, dc_pend;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_ic_cnt"}, ic_cnt, m_ic);
        check({tag, "_dc_cnt"}, dc_cnt, m_dc);
        check({tag, "_conflicts"}, conflicts, m_conf);
        check({tag, "_timeouts"}, timeouts, m_to);
    endtask

    task automatic model_reset();
        m_last_dc = 1'b1;
        m_ic = 0; m_dc = 0; m_conf = 0; m_to = 0;
        ic_pend = 1'b0; dc_pend = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        stat_clr = 1'b0; l2_ack = 1'b0;
        ic_addr = '0; dc_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", {ic_gnt, dc_gnt, ic_done, dc_done, err, l2_req, l2_we}, 0);
        check("rst_addr", l2_addr, 0);
        check_cnt("rst");
        #2 rst_n = 1'b1;
        step();
    endtask

    // One transaction: raise requests, expect the winner, ack after k ISSUE edges
    // (k > TO means no ack), then expect done/err. DUT must be in IDLE on entry.
    task automatic run_txn(input logic want_ic, input logic want_dc,
                           input logic [AW-1:0] ia, input logic [AW-1:0] da,
                           input logic we, input int k, input logic clr);
        logic          both, win_dc, exp_err, exp_we;
        logic [AW-1:0] exp_addr;
        int            end_e;
        if (!ic_pend && want_ic) begin ic_addr = ia; ic_req = 1'b1; ic_pend = 1'b1; end
        if (!dc_pend && want_dc) begin dc_addr = da; dc_we = we; dc_req = 1'b1; dc_pend = 1'b1; end
        if (!ic_pend && !dc_pend) begin
            step();
            check("idle_nogrant", {ic_gnt, dc_gnt, l2_req}, 0);
            return;
        end
        both     = ic_pend && dc_pend;
        win_dc   = both ? !m_last_dc : dc_pend;
        exp_addr = win_dc ? dc_addr : ic_addr;
        exp_we   = win_dc ? dc_we : 1'b0;
        stat_clr = clr;
        step();
        stat_clr = 1'b0;
        if (clr) begin
            m_ic = 0; m_dc = 0; m_conf = 0; m_to = 0;
        end else begin
            if (both) m_conf++;
            if (win_dc) m_dc++; else m_ic++;
        end
        m_last_dc = win_dc;
        check("gnt", {ic_gnt, dc_gnt}, win_dc ? 2'b01 : 2'b10);
        check("gnt_l2_req", l2_req, 1);
        check("gnt_addr", l2_addr, exp_addr);
        check("gnt_we", l2_we, exp_we);
        check_cnt("gnt");
        if (win_dc) begin dc_req = 1'b0; dc_pend = 1'b0; end
        else        begin ic_req = 1'b0; ic_pend = 1'b0; end

        if (k >= 1 && k <= TO) begin end_e = k;  exp_err = 1'b0; end
        else                   begin end_e = TO; exp_err = 1'b1; end
        for (int j = 1; j <= end_e; j++) begin
            if (j > 1) begin
                check("issue_l2_req", l2_req, 1);
                check("issue_quiet", {ic_gnt, dc_gnt, ic_done, dc_done}, 0);
            end
            l2_ack = (j == k);
            step();
        end
        l2_ack = 1'b0;
        if (exp_err) m_to++;
        check("resp_l2_req", l2_req, 0);
        check("resp_nodone", {ic_done, dc_done}, 0);
        check("resp_timeouts", timeouts, m_to);
        step();
        check("done", {ic_done, dc_done}, win_dc ? 2'b01 : 2'b10);
        check("done_err", err, exp_err);
        check("done_addr", l2_addr, exp_addr);
        check("done_we", l2_we, exp_we);
        check("done_l2_req", l2_req, 0);
        check_cnt("done");
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();

        // Single IC request, ack two cycles after grant
        run_txn(1'b1, 1'b0, 26'h0ABCDEF, '0, 1'b0, 2, 1'b0);
        check("first_conflicts", conflicts, 0);

        // Back-to-back ties, immediate ack
        do_reset();
        for (int t = 0; t < 4; t++)
            run_txn(1'b1, 1'b1, AW'($urandom), AW'($urandom), 1'($urandom), 1, 1'b0);
        check("tie_conflicts", conflicts, 4);
        check("tie_ic_cnt", ic_cnt, 2);
        check("tie_dc_cnt", dc_cnt, 2);

        // DC write-back timeout, then ack exactly on expiry cycle
        do_reset();
        run_txn(1'b0, 1'b1, '0, 26'h1234567, 1'b1, TO + 5, 1'b0);
        check("to_timeouts", timeouts, 1);
        run_txn(1'b0, 1'b1, '0, 26'h2345678, 1'b0, TO, 1'b0);
        check("expiry_ack_timeouts", timeouts, 1);

        // Reset mid-ISSUE
        ic_addr = 26'h0111111; ic_req = 1'b1;
        step();
        check("mid_gnt", ic_gnt, 1);
        ic_req = 1'b0;
        step();
        check("mid_issue", l2_req, 1);
        rst_n = 1'b0;
        #1;
        check("async_l2_req", l2_req, 0);
        model_reset();
        check_cnt("async");
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check("post_rst_nodone", {ic_done, dc_done, l2_req}, 0);
        end
        run_txn(1'b1, 1'b1, 26'h0222222, 26'h0333333, 1'b1, 1, 1'b0);
        check("post_rst_tie_ic", ic_cnt, 1);
        run_txn(1'b0, 1'b0, '0, '0, 1'b0, 1, 1'b0);

        // Clear on the same edge as a grant
        run_txn(1'b1, 1'b0, 26'h0444444, '0, 1'b0, 3, 1'b1);
        check("clr_ic_cnt", ic_cnt, 0);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            run_txn(1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
                    1'($urandom), int'($urandom_range(1, TO + 3)),
                    ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Arbitrates the single next-level (L2) request port between the instruction cache miss path and the data cache miss/write-back path. It grants one requester at a time, registers the 26-bit line address, drives a request/acknowledge handshake to L2 and guards each transaction with a timeout watchdog. It also keeps grant, conflict and timeout statistics for the statistics module. It sits between the two L1 caches and the next-level cache model.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles spent in ISSUE without `l2_ack` before the transaction is aborted (range 1..65535).
- AW, 26: line-address width (address bits [31:6]).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ic_req`  in  1  instruction cache request; held high until `ic_gnt` is seen.
- `ic_addr`  in  AW  instruction cache line address; stable while `ic_req` is high.
- `dc_req`  in  1  data cache request; held until `dc_gnt`.
- `dc_addr`  in  AW  data cache line address.
- `dc_we`  in  1  1 = write-back, 0 = line fill.
- `stat_clr`  in  1  synchronous clear of all statistics counters.
- `ic_gnt`, `dc_gnt`  out  1  one-cycle grant pulse.
- `ic_done`, `dc_done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with a done pulse; 1 = the transaction timed out.
- `l2_req`  out  1  request to L2; level signal.
- `l2_addr`  out  AW  registered line address.
- `l2_we`  out  1  registered write flag (always 0 for instruction cache transactions).
- `l2_ack`  in  1  L2 completion; sampled only in ISSUE.
- `ic_cnt`, `dc_cnt`, `conflicts`, `timeouts`  out  32  statistics counters.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP.
- **IDLE**
  - If neither requester is asserting, stay in IDLE.
  - If exactly one requester is asserting, grant it.
  - If both are asserting, grant the requester that was not granted last (`last` register), and increment `conflicts`.
  - On a grant: latch the owner, latch `l2_addr` and `l2_we` from the winner, pulse its gnt, set `last` to the winner, increment `ic_cnt` or `dc_cnt`, clear the watchdog, and go to ISSUE.
- **ISSUE**
  - `l2_req` = 1 and the watchdog increments each cycle.
  - If `l2_ack` = 1, go to RESP with `err` = 0.
  - Otherwise, if the watchdog equals TIMEOUT-1, go to RESP with `err` = 1 and increment `timeouts`.
  - If `l2_ack` arrives in the same cycle the watchdog expires, the ack wins: `err` = 0 and `timeouts` is not incremented.
- **RESP**
  - `l2_req` = 0; pulse the owner's done line with `err`; go to IDLE.
  - Requests are never sampled in RESP.
- Statistics counters:
  - Counters wrap at 2^32 with no saturation.
  - `stat_clr` zeroes all four counters. It overrides any increment in the same cycle and does not disturb the FSM.
- Requests raised while another transaction is in flight wait, held by the requester. No request is dropped.

## Timing
- Reset values:
  - FSM = IDLE; `last` = DC, so the instruction cache wins the first tie.
  - All gnt, done, `err`, `l2_req`, `l2_we` = 0; `l2_addr` = 0; all counters = 0.
- A reset assertion mid-transaction aborts immediately: `l2_req` drops asynchronously and no done pulse is issued.
- Request sampled high at edge N:
  - gnt and `l2_req` are high after edge N.
  - With `l2_ack` sampled at edge N+k (k ≥ 1), done is high after edge N+k+1.
  - The next grant is possible at edge N+k+2.
- Minimum transaction is 3 cycles (ack at the first ISSUE edge): IDLE→ISSUE→RESP→IDLE.
- Timeout: `l2_ack` never asserted; done and `err` are high after edge N+TIMEOUT+1.
- The requester must drop req the cycle after gnt. A req still high in IDLE is treated as a new request.
- `l2_addr` and `l2_we` stay stable from grant through RESP.
- All outputs are registered.

## Test plan
- Reset, then only `ic_req` with `ic_addr`=26'h0ABCDEF and ack 2 cycles later:
  - `ic_gnt` pulses at cycle 1 and `l2_addr`=26'h0ABCDEF.
  - `ic_done` pulses with `err`=0.
  - `ic_cnt`=1; `conflicts`=0.
- `ic_req` and `dc_req` both high continuously for 4 transactions, ack immediate:
  - Grant order IC, DC, IC, DC.
  - `conflicts`=4 (every grant sees both requesters asserting).
  - `ic_cnt`=2, `dc_cnt`=2.
  - Every 3 cycles `l2_we` follows `dc_we` only on DC transactions.
- TIMEOUT=8, DC write-back with no ack:
  - `dc_done` and `err`=1 after edge N+9.
  - `timeouts`=1; `l2_req` low in RESP.
- TIMEOUT=8, ack asserted exactly on the expiry cycle: `err`=0 and `timeouts` stays 0.
- `rst_n` pulled low mid-ISSUE, then released:
  - `l2_req`=0 immediately and no done pulse.
  - Counters are 0.
  - The next IC/DC tie grants IC.
- `stat_clr` asserted on the same edge as a grant: the counters read 0 afterward (clear beats increment) and the transaction completes normally.
